// File: rtl/pc_fetch_sequencer.sv
// Program-counter and instruction-fetch sequencer: drives the PC register's IN every
// cycle, issues request/ready fetches, squashes fetches overtaken by a redirect.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_CUR,
    output logic [31:0] PC_IN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    output logic        INSTR_VALID,
    input  logic        STALL,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        JUMP,
    input  logic [31:0] JUMP_TARGET,
    output logic [31:0] FETCH_COUNT
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [31:0] pend_addr_reg, pend_addr_next;
    logic [31:0] count_reg, count_next;

    logic        redirect_active;
    logic [31:0] redirect_target;
    logic        req_w;
    logic        complete_w;
    logic        squash_w;

    assign redirect_active = JUMP | BR_TAKEN;
    assign redirect_target = JUMP ? JUMP_TARGET : BR_TARGET;

    // Request is derived separately from the output mux so completion has no comb loop.
    assign req_w      = !RST && ((state_reg == FETCH && !STALL) || state_reg == WAIT);
    assign complete_w = req_w & IMEM_READY;
    assign squash_w   = redirect_active | pend_valid_reg;

    assign IMEM_REQ    = req_w;
    assign IMEM_ADDR   = PC_CUR;
    assign FETCH_COUNT = count_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= BOOT;
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= 32'h0000_0000;
            count_reg      <= 32'h0000_0000;
        end else begin
            state_reg      <= state_next;
            pend_valid_reg <= pend_valid_next;
            pend_addr_reg  <= pend_addr_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pend_valid_next = pend_valid_reg;
        pend_addr_next  = pend_addr_reg;
        count_next      = INSTR_VALID ? count_reg + 32'd1 : count_reg;
        case (state_reg)
            BOOT: state_next = FETCH;
            FETCH, WAIT: begin
                if (complete_w) begin
                    pend_valid_next = 1'b0;
                    state_next      = STALL ? HOLD : FETCH;
                end else begin
                    if (redirect_active) begin
                        pend_valid_next = 1'b1;
                        pend_addr_next  = redirect_target;
                    end
                    if (state_reg == FETCH)
                        state_next = STALL ? HOLD : WAIT;
                end
            end
            HOLD: begin
                if (STALL) begin
                    if (redirect_active) begin
                        pend_valid_next = 1'b1;
                        pend_addr_next  = redirect_target;
                    end
                end else begin
                    // A redirect arriving on the exit cycle is applied directly via PC_IN.
                    pend_valid_next = 1'b0;
                    state_next      = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        PC_IN       = PC_CUR;
        INSTR_VALID = 1'b0;
        case (state_reg)
            BOOT: PC_IN = RESET_VECTOR;
            HOLD: begin
                if (!STALL) begin
                    if (redirect_active)
                        PC_IN = redirect_target;
                    else if (pend_valid_reg)
                        PC_IN = pend_addr_reg;
                end
            end
            default: PC_IN = PC_CUR;
        endcase
        if (complete_w) begin
            if (squash_w) begin
                PC_IN = redirect_active ? redirect_target : pend_addr_reg;
            end else begin
                INSTR_VALID = 1'b1;
                PC_IN       = PC_CUR + 32'd4;
            end
        end
        if (RST) begin
            PC_IN       = RESET_VECTOR;
            INSTR_VALID = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench: stimulus pushes expected fetch addresses into a scoreboard queue,
// a monitor pops and compares on every delivered instruction.
module tb_pc_fetch_sequencer;

    logic        CLK;
    logic        RST;
    logic [31:0] PC_CUR;
    logic [31:0] PC_IN;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READY;
    logic        INSTR_VALID;
    logic        STALL;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        JUMP;
    logic [31:0] JUMP_TARGET;
    logic [31:0] FETCH_COUNT;

    logic [31:0] pc_q;
    logic        pc_force;
    logic [31:0] pc_force_val;

    int          n_checks;
    int          n_errors;
    logic [31:0] sb_q[$];
    logic [31:0] exp_count;

    pc_fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PC_CUR      (PC_CUR),
        .PC_IN       (PC_IN),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_READY  (IMEM_READY),
        .INSTR_VALID (INSTR_VALID),
        .STALL       (STALL),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .JUMP        (JUMP),
        .JUMP_TARGET (JUMP_TARGET),
        .FETCH_COUNT (FETCH_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Enable-less PC register; the preload path lets a test start from an arbitrary PC.
    initial pc_q = 32'hDEAD_BEE0;
    always @(posedge CLK) pc_q <= pc_force ? pc_force_val : PC_IN;
    assign PC_CUR = pc_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic stl,
                         input logic br, input logic [31:0] bt,
                         input logic jmp, input logic [31:0] jt);
        @(negedge CLK);
        RST = r; IMEM_READY = rdy; STALL = stl;
        BR_TAKEN = br; BR_TARGET = bt; JUMP = jmp; JUMP_TARGET = jt;
        #1;
    endtask

    // Monitor: samples late in the cycle, after stimulus and pushes have settled.
    initial begin
        logic [31:0] exp_addr;
        exp_count = 32'd0;
        forever begin
            @(negedge CLK);
            #3;
            if (RST) begin
                exp_count = 32'd0;
            end else if (INSTR_VALID) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, INSTR_VALID}, 32'd0);
                end else begin
                    exp_addr = sb_q.pop_front();
                    $display("deliver addr=%h pc_in=%h count=%0d", IMEM_ADDR, PC_IN, FETCH_COUNT);
                    chk("deliver_addr", IMEM_ADDR, exp_addr);
                    chk("deliver_pc_in", PC_IN, exp_addr + 32'd4);
                    chk("deliver_count", FETCH_COUNT, exp_count);
                    exp_count = exp_count + 32'd1;
                end
            end
        end
    end

    initial begin
        n_checks = 0; n_errors = 0;
        pc_force = 1'b0; pc_force_val = 32'h0;
        RST = 1'b1; IMEM_READY = 1'b0; STALL = 1'b0;
        BR_TAKEN = 1'b0; BR_TARGET = 32'h0; JUMP = 1'b0; JUMP_TARGET = 32'h0;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            chk("rst_pc_in", PC_IN, 32'h0);
            chk("rst_req", {31'b0, IMEM_REQ}, 32'd0);
            chk("rst_valid", {31'b0, INSTR_VALID}, 32'd0);
            chk("rst_count", FETCH_COUNT, 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("boot_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("boot_pc_in", PC_IN, 32'h0);

        // Streaming with zero-wait memory
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            chk("stream_req", {31'b0, IMEM_REQ}, 32'd1);
            chk("stream_addr", IMEM_ADDR, 32'(i * 4));
            sb_q.push_back(32'(i * 4));
        end

        // Stall into HOLD and preload the PC near the top of memory
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("stream_count", FETCH_COUNT, 32'd4);
        chk("stall_req", {31'b0, IMEM_REQ}, 32'd0);
        pc_force = 1'b1; pc_force_val = 32'hFFFF_FFFC;
        drive(0, 0, 0, 0, 0, 0, 0);
        pc_force = 1'b0;
        chk("hold_exit_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("hold_exit_pc_in", PC_IN, 32'hFFFF_FFFC);

        // Wait states, ready on the third request cycle, PC wraps
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk("wait_req", {31'b0, IMEM_REQ}, 32'd1);
            chk("wait_addr", IMEM_ADDR, 32'hFFFF_FFFC);
            chk("wait_valid", {31'b0, INSTR_VALID}, 32'd0);
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("wrap_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        chk("wrap_pc_in", PC_IN, 32'h0);
        sb_q.push_back(32'hFFFF_FFFC);

        // Jump during WAIT, completion two cycles later is squashed
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rw_fetch_addr", IMEM_ADDR, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        chk("rw_hold_pc_in", PC_IN, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rw_wait_addr", IMEM_ADDR, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("rw_squash_valid", {31'b0, INSTR_VALID}, 32'd0);
        chk("rw_squash_pc_in", PC_IN, 32'h1234_5678);

        // Jump beats branch in a completion cycle
        drive(0, 1, 0, 1, 32'h0000_0080, 1, 32'h0000_0040);
        chk("prio_addr", IMEM_ADDR, 32'h1234_5678);
        chk("prio_pc_in", PC_IN, 32'h0000_0040);
        chk("prio_valid", {31'b0, INSTR_VALID}, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("prio_next_addr", IMEM_ADDR, 32'h0000_0040);
        sb_q.push_back(32'h0000_0040);

        // Four-cycle stall with a branch latched in the second HOLD cycle
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("sb_fetch_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("sb_fetch_pc_in", PC_IN, 32'h44);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("sb_hold1_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("sb_hold1_pc", PC_CUR, 32'h44);
        drive(0, 0, 1, 1, 32'hABCD_EF00, 0, 0);
        chk("sb_hold2_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("sb_hold2_pc_in", PC_IN, 32'h44);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("sb_hold3_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("sb_hold3_pc_in", PC_IN, 32'h44);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("sb_exit_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("sb_exit_pc_in", PC_IN, 32'hABCD_EF00);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("sb_fetch_addr", IMEM_ADDR, 32'hABCD_EF00);
        sb_q.push_back(32'hABCD_EF00);

        // Reset abandons a WAIT; ready during BOOT is ignored
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_count", FETCH_COUNT, 32'd7);
        chk("pre_rst_addr", IMEM_ADDR, 32'hABCD_EF04);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_wait_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("rst_wait_pc_in", PC_IN, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("reboot_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("reboot_valid", {31'b0, INSTR_VALID}, 32'd0);
        chk("reboot_count", FETCH_COUNT, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("reboot_fetch_addr", IMEM_ADDR, 32'h0);
        sb_q.push_back(32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("final_count", FETCH_COUNT, 32'd1);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
